// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - binary to BCD converter with multiplexed 4-digit 7-segment scan
module display_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [13:0] value_in,
    output logic [3:0]  bcd_out,
    output logic [3:0]  digit_sel,
    output logic        busy,
    output logic        overflow
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [13:0]   val_q, val_d;
    logic [15:0]   scr_q, scr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   disp_q, disp_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    dsel_q, dsel_d;
    logic [3:0]    bcd_q, bcd_d;

    logic [15:0]   adj;
    logic [15:0]   upper;
    logic [3:0]    bit_idx;

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        adj     = scr_q;
        bit_idx = 4'd13 - cnt_q;

        for (int i = 0; i < 4; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    val_d   = value_in;
                    scr_d   = 16'h0000;
                    cnt_d   = 4'd0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                scr_d = {adj[14:0], val_q[bit_idx]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // Values above 9999 cannot be shown in four digits, so all digits go dark
                if (val_q > 14'd9999) begin
                    disp_d = 16'hFFFF;
                    ovf_d  = 1'b1;
                end else begin
                    disp_d = scr_q;
                    ovf_d  = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end

        // Select and blank from the next index so bcd_out and digit_sel switch on the same edge
        dsel_d = ~(4'b0001 << idx_d);
        upper  = disp_q >> {idx_d, 2'b00};
        bcd_d  = upper[3:0];
        if (BLANK_LZ && (idx_d != 2'd0) && (upper == 16'h0000)) begin
            bcd_d = 4'hF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            val_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= 2'd0;
            dsel_q  <= 4'b1110;
            bcd_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            dsel_q  <= dsel_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign overflow  = ovf_q;
    assign digit_sel = dsel_q;
    assign bcd_out   = bcd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed scoreboard bench for display_scan_ctrl
module tb_display_scan_ctrl;

    localparam int SCAN_DIV = 4;
    localparam bit BLANK_LZ = 1'b1;

    logic        clk;
    logic        rst;
    logic        load;
    logic [13:0] value_in;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_sel;
    logic        busy;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;
    logic [16:0] sb_q[$];

    display_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(BLANK_LZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value_in (value_in),
        .bcd_out  (bcd_out),
        .digit_sel(digit_sel),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected {overflow, d3, d2, d1, d0} built by decimal arithmetic
    function automatic logic [16:0] model(input int v);
        logic [15:0] r;
        int p;
        int d;
        if (v > 9999) return {1'b1, 16'hFFFF};
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            d = (v / p) % 10;
            if (BLANK_LZ && i > 0 && v < p) d = 15;
            r[4*i +: 4] = 4'(d);
            p = p * 10;
        end
        return {1'b0, r};
    endfunction

    task automatic do_load(input int v, input int late_at);
        int cnt;
        @(negedge clk);
        load = 1'b1;
        value_in = 14'(v);
        @(negedge clk);
        load = 1'b0;
        sb_q.push_back(model(v));
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (cnt == late_at) begin
                load = 1'b1;
                value_in = 14'd99;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
        chk($sformatf("busy_cycles_%0d", v), cnt, 15);
        @(negedge clk);
    endtask

    task automatic check_scan(input string tag);
        logic [16:0] e;
        logic [3:0]  target;
        int cnt;
        e = sb_q.pop_front();
        chk({tag, "_ovf"}, overflow, e[16]);
        for (int k = 0; k < 4; k++) begin
            target = ~(4'b0001 << k);
            cnt = 0;
            while (digit_sel !== target && cnt < 64) begin
                @(negedge clk);
                cnt++;
            end
            chk($sformatf("%s_sel%0d", tag, k), digit_sel, target);
            chk($sformatf("%s_dig%0d", tag, k), bcd_out, e[4*k +: 4]);
        end
    endtask

    logic [3:0] sel_pat[4];
    logic [3:0] rst_dig[4];

    initial begin
        sel_pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rst_dig = '{4'h0, 4'hF, 4'hF, 4'hF};
        rst = 1'b1;
        load = 1'b0;
        value_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        for (int n = 0; n < 16; n++) begin
            chk($sformatf("idle_sel_c%0d", n), digit_sel, sel_pat[(n / 4) % 4]);
            chk($sformatf("idle_bcd_c%0d", n), bcd_out, rst_dig[(n / 4) % 4]);
            @(negedge clk);
        end

        do_load(1234, -1);
        check_scan("v1234");
        do_load(9999, -1);
        check_scan("v9999");
        do_load(0, -1);
        check_scan("v0");
        do_load(10000, -1);
        check_scan("v10000");
        do_load(7, -1);
        check_scan("v7");
        do_load(42, 5);
        check_scan("v42");

        @(negedge clk);
        load = 1'b1;
        value_in = 14'd1234;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_busy_pre", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_ovf", overflow, 1'b0);
        chk("abort_sel", digit_sel, 4'b1110);
        chk("abort_bcd", bcd_out, 4'h0);
        sb_q.push_back(model(0));
        check_scan("abort");
        repeat (20) @(negedge clk);
        chk("abort_busy_late", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
